// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for pipe_stage_reg: upstream, downstream and control inputs.
// The bench drives through master; the stage register connects through slave.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned DEPTH  = 1
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              start_i;
    logic              flush_i;
    logic              bubble_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] data_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] data_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [OCC_W-1:0]  occupancy_o;

    modport master (
        output start_i, flush_i, bubble_i, in_valid_i, data_i, ctrl_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, ctrl_o, occupancy_o
    );

    modport slave (
        input  start_i, flush_i, bubble_i, in_valid_i, data_i, ctrl_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, ctrl_o, occupancy_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline register chain with valid tracking, back-pressure,
// bubble insertion and flush; control is zeroed in every invalid stage.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned DEPTH  = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipe_stage_reg_if.slave bus
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [OCC_W-1:0]             occ_q,   occ_d;
    logic [DEPTH-1:0]             rdy_c;

    // A stage can take new content if it is empty or anything below it can move.
    always_comb begin : ready_chain
        logic acc;
        acc   = bus.out_ready_i;
        rdy_c = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            acc      = acc | ~valid_q[k];
            rdy_c[k] = acc;
        end
    end

    assign bus.in_ready_o = bus.start_i & ~bus.flush_i & ~bus.bubble_i & rdy_c[0];

    // Next state: flush beats freeze beats advance.
    always_comb begin : next_state
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (bus.flush_i) begin
            valid_d = '0;
            ctrl_d  = '0;
        end else if (bus.start_i) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (rdy_c[k]) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                    ctrl_d[k]  = valid_q[k-1] ? ctrl_q[k-1] : '0;
                end
            end
            if (rdy_c[0]) begin
                if (bus.bubble_i || !bus.in_valid_i) begin
                    valid_d[0] = 1'b0;
                    ctrl_d[0]  = '0;
                end else begin
                    valid_d[0] = 1'b1;
                    data_d[0]  = bus.data_i;
                    ctrl_d[0]  = bus.ctrl_i;
                end
            end
        end
    end

    always_comb begin : occupancy_next
        occ_d = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            occ_q   <= occ_d;
        end
    end

    assign bus.out_valid_o = valid_q[DEPTH-1];
    assign bus.data_o      = data_q[DEPTH-1];
    assign bus.ctrl_o      = ctrl_q[DEPTH-1];
    assign bus.occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg (DEPTH=3) against a slot-level
// reference model plus an in-order delivery scoreboard.
module tb_pipe_stage_reg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned DEPTH  = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: slot contents plus the queue of accepted-but-undelivered data.
    bit              m_valid [DEPTH];
    logic [DATA_W-1:0] m_data [DEPTH];
    logic [CTRL_W-1:0] m_ctrl [DEPTH];
    logic [DATA_W-1:0] sb_q [$];

    logic              last_ov, last_ir;
    logic [DATA_W-1:0] last_do;
    logic [CTRL_W-1:0] last_co;
    logic [1:0]        last_occ;

    function automatic int m_occ();
        int n = 0;
        for (int k = 0; k < int'(DEPTH); k++) n += int'(m_valid[k]);
        return n;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < int'(DEPTH); k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_ctrl[k]  = '0;
        end
        sb_q.delete();
    endtask

    task automatic drive(input bit st, input bit fl, input bit bb, input bit iv,
                         input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input bit ordy);
        bus.start_i     = st;
        bus.flush_i     = fl;
        bus.bubble_i    = bb;
        bus.in_valid_i  = iv;
        bus.data_i      = d;
        bus.ctrl_i      = c;
        bus.out_ready_i = ordy;
    endtask

    // One clock: drive at negedge, check mid-cycle, advance model at the posedge.
    task automatic cyc(input bit st, input bit fl, input bit bb, input bit iv,
                       input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input bit ordy);
        int h;
        bit exp_ir;
        @(negedge clk_i);
        drive(st, fl, bb, iv, d, c, ordy);
        #1;
        h = -1;
        if (ordy) h = int'(DEPTH) - 1;
        else for (int k = 0; k < int'(DEPTH); k++) if (!m_valid[k]) h = k;
        exp_ir = st && !fl && !bb && (h >= 0);

        last_ov = bus.out_valid_o; last_do = bus.data_o; last_co = bus.ctrl_o;
        last_occ = bus.occupancy_o; last_ir = bus.in_ready_o;
        check_eq("in_ready",  64'(bus.in_ready_o),  64'(exp_ir));
        check_eq("out_valid", 64'(bus.out_valid_o), 64'(m_valid[DEPTH-1]));
        check_eq("ctrl_o",    64'(bus.ctrl_o),      64'(m_ctrl[DEPTH-1]));
        check_eq("occupancy", 64'(bus.occupancy_o), 64'(m_occ()));
        if (m_valid[DEPTH-1]) check_eq("data_o", 64'(bus.data_o), 64'(m_data[DEPTH-1]));

        if (st && !fl && ordy && m_valid[DEPTH-1]) begin
            check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) check_eq("sb_order", 64'(bus.data_o), 64'(sb_q.pop_front()));
        end
        if (exp_ir && iv) sb_q.push_back(d);

        if (fl) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                m_valid[k] = 1'b0;
                m_ctrl[k]  = '0;
            end
            sb_q.delete();
        end else if (st) begin
            for (int k = h; k >= 1; k--) begin
                m_valid[k] = m_valid[k-1];
                m_data[k]  = m_data[k-1];
                m_ctrl[k]  = m_ctrl[k-1];
            end
            if (h >= 0) begin
                if (bb || !iv) begin
                    m_valid[0] = 1'b0;
                    m_ctrl[0]  = '0;
                end else begin
                    m_valid[0] = 1'b1;
                    m_data[0]  = d;
                    m_ctrl[0]  = c;
                end
            end
        end
        @(posedge clk_i);
    endtask

    // Asynchronous reset checked mid-cycle, away from any edge.
    task automatic do_reset();
        @(negedge clk_i);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
        check_eq("rst_data_o",    64'(bus.data_o),      64'(0));
        check_eq("rst_ctrl_o",    64'(bus.ctrl_o),      64'(0));
        check_eq("rst_occupancy", 64'(bus.occupancy_o), 64'(0));
        check_eq("rst_in_ready",  64'(bus.in_ready_o),  64'(1));
        m_reset();
        bus.start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    logic              snap_ov;
    logic [DATA_W-1:0] snap_do;
    logic [1:0]        snap_occ;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        m_reset();
        do_reset();

        // Streaming: three back-to-back entries, first visible three samples later.
        cyc(1, 0, 0, 1, 32'h11, 7'h01, 1);
        cyc(1, 0, 0, 1, 32'h22, 7'h02, 1);
        cyc(1, 0, 0, 1, 32'h33, 7'h03, 1);
        cyc(1, 0, 0, 0, '0, '0, 1);
        check_eq("stream0", 64'(last_do), 64'(32'h11));
        cyc(1, 0, 0, 0, '0, '0, 1);
        check_eq("stream1", 64'(last_do), 64'(32'h22));
        cyc(1, 0, 0, 0, '0, '0, 1);
        check_eq("stream2", 64'(last_do), 64'(32'h33));
        cyc(1, 0, 0, 0, '0, '0, 1);

        // Back-pressure: fill, stall five cycles, then drain.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 32'hA1 + 32'(i), 7'h11, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 32'hBAD, 7'h22, 0);
        check_eq("bp_full_occ", 64'(last_occ), 64'(3));
        check_eq("bp_full_rdy", 64'(last_ir), 64'(0));
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, '0, '0, 1);

        // Bubble: refused on the hazard cycle, accepted next.
        cyc(1, 0, 1, 1, 32'h44, 7'h7F, 1);
        check_eq("bubble_rdy", 64'(last_ir), 64'(0));
        cyc(1, 0, 0, 1, 32'h44, 7'h7F, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, '0, '0, 1);

        // Flush with start low.
        cyc(1, 0, 0, 1, 32'h51, 7'h05, 0);
        cyc(1, 0, 0, 1, 32'h52, 7'h06, 0);
        cyc(0, 1, 0, 1, 32'h53, 7'h07, 1);
        check_eq("flush_pre_occ", 64'(last_occ), 64'(2));
        cyc(1, 0, 0, 0, '0, '0, 1);
        check_eq("flush_occ", 64'(last_occ), 64'(0));
        check_eq("flush_ov",  64'(last_ov),  64'(0));
        check_eq("flush_co",  64'(last_co),  64'(0));

        // Freeze with a full pipe and downstream ready.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 32'hC1 + 32'(i), 7'h09, 0);
        cyc(0, 0, 0, 1, 32'hDEAD, 7'h0A, 1);
        snap_ov = last_ov; snap_do = last_do; snap_occ = last_occ;
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 0, 0, 0, '0, '0, 1);
            check_eq("freeze_ov",  64'(last_ov),  64'(snap_ov));
            check_eq("freeze_do",  64'(last_do),  64'(snap_do));
            check_eq("freeze_occ", 64'(last_occ), 64'(snap_occ));
        end
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, '0, '0, 1);

        // Reset mid-stream.
        cyc(1, 0, 0, 1, 32'hE1, 7'h0B, 0);
        cyc(1, 0, 0, 1, 32'hE2, 7'h0C, 0);
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 9) < 7,
                DATA_W'($urandom), CTRL_W'($urandom), $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, '0, '0, 1);
        check_eq("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
